// File: rtl/ppu_sched.sv
// ppu_sched: layer-job scheduler in front of the PPU.
//   Queues up to two job descriptors {nvec, relu}, issues one o_ppu_start per
//   accumulator tile, holds o_relu_en for the whole job and stalls the next
//   vector until quantize returns its scale factor (vsq buffer reuse).
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_job_valid/o_job_ready         job push handshake, i_job_nvec/i_job_relu payload
//   i_tile_valid/o_tile_ack         accumulator tile ready / consumed
//   o_ppu_start, o_relu_en          PPU start pulse and ReLU enable
//   i_sf_valid                      quantize finished a vector
//   i_abort, i_err_clr              flush request, clear sticky timeout error
//   o_busy, o_job_done, o_vec_cnt   status
//   o_err_timeout                   sticky quantize timeout flag
module ppu_sched #(
   parameter int NVEC_W        = 8,
   parameter int TILE_CYC      = 16,
   parameter int TILES_PER_VEC = 4,
   parameter int QTO_W         = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_job_valid,
   output logic              o_job_ready,
   input  logic [NVEC_W-1:0] i_job_nvec,
   input  logic              i_job_relu,
   input  logic              i_tile_valid,
   output logic              o_tile_ack,
   output logic              o_ppu_start,
   output logic              o_relu_en,
   input  logic              i_sf_valid,
   input  logic              i_abort,
   input  logic              i_err_clr,
   output logic              o_busy,
   output logic              o_job_done,
   output logic [NVEC_W-1:0] o_vec_cnt,
   output logic              o_err_timeout
);

   localparam int ACC_W  = (TILE_CYC > 1) ? $clog2(TILE_CYC) : 1;
   localparam int TILE_W = (TILES_PER_VEC > 1) ? $clog2(TILES_PER_VEC) : 1;
   localparam logic [ACC_W-1:0]  ACC_LAST  = ACC_W'(TILE_CYC - 1);
   localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(TILES_PER_VEC - 1);
   // expiry on the (2**QTO_W-1)th WAIT_QUANT cycle; counter starts at 0
   localparam logic [QTO_W-1:0]  QTO_LAST  = QTO_W'((2**QTO_W) - 2);
   localparam logic [NVEC_W-1:0] VEC_ONE   = NVEC_W'(1);

   typedef struct packed {
      logic [NVEC_W-1:0] nvec;
      logic              relu;
   } job_t;

   typedef enum logic [2:0] {
      IDLE, LOAD, WAIT_TILE, RUN, WAIT_QUANT, DONE
   } state_t;

   state_t            state;
   job_t              fifo_q [2];
   logic              wr_ptr, rd_ptr;
   logic [1:0]        fifo_cnt;
   logic              rdy_q;
   logic              abort_q;
   logic [NVEC_W-1:0] nvec_q;
   logic [ACC_W-1:0]  acc_cnt;
   logic [TILE_W-1:0] tile_cnt;
   logic [QTO_W-1:0]  qto_cnt;

   logic fifo_full, fifo_empty, flush, push, pop, qto_exp, last_vec;
   job_t head, push_job;

   assign fifo_full  = (fifo_cnt == 2'd2);
   assign fifo_empty = (fifo_cnt == 2'd0);
   // rdy_q keeps ready low through reset and rises on the first clock after it
   assign o_job_ready = rdy_q & ~fifo_full & ~abort_q;
   // a RUN-time abort keeps the queue flushed until the tile drains
   assign flush    = i_abort | abort_q;
   assign push     = i_job_valid & o_job_ready & ~flush;
   assign pop      = ~fifo_empty & ~i_abort & ((state == IDLE) | (state == DONE));
   assign head     = fifo_q[rd_ptr];
   assign push_job = '{nvec: i_job_nvec, relu: i_job_relu};
   assign qto_exp  = (qto_cnt == QTO_LAST);
   assign last_vec = ((o_vec_cnt + VEC_ONE) == nvec_q);
   assign o_busy   = (state != IDLE);

   // job FIFO
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= 2'd0;
         rdy_q     <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (flush) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
         end else begin
            if (push) begin
               fifo_q[wr_ptr] <= push_job;
               wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
               2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
               2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
               default: fifo_cnt <= fifo_cnt;
            endcase
         end
      end
   end

   // scheduler FSM with registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         abort_q       <= 1'b0;
         nvec_q        <= '0;
         acc_cnt       <= '0;
         tile_cnt      <= '0;
         qto_cnt       <= '0;
         o_vec_cnt     <= '0;
         o_relu_en     <= 1'b0;
         o_ppu_start   <= 1'b0;
         o_tile_ack    <= 1'b0;
         o_job_done    <= 1'b0;
         o_err_timeout <= 1'b0;
      end else begin
         o_ppu_start <= 1'b0;
         o_tile_ack  <= 1'b0;
         o_job_done  <= 1'b0;
         if (i_err_clr) o_err_timeout <= 1'b0;

         case (state)
            IDLE: begin
               if (pop) begin
                  nvec_q    <= head.nvec;
                  o_relu_en <= head.relu;
                  o_vec_cnt <= '0;
                  tile_cnt  <= '0;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               if (i_abort || (nvec_q == '0)) begin
                  o_job_done <= 1'b1;
                  state      <= DONE;
               end else begin
                  state <= WAIT_TILE;
               end
            end
            WAIT_TILE: begin
               if (i_abort) begin
                  o_job_done <= 1'b1;
                  state      <= DONE;
               end else if (i_tile_valid) begin
                  o_ppu_start <= 1'b1;
                  o_tile_ack  <= 1'b1;
                  acc_cnt     <= '0;
                  state       <= RUN;
               end
            end
            RUN: begin
               // a tile in flight cannot be cut; remember the abort for its end
               if (i_abort) abort_q <= 1'b1;
               if (acc_cnt == ACC_LAST) begin
                  acc_cnt <= '0;
                  if (abort_q || i_abort) begin
                     abort_q    <= 1'b0;
                     tile_cnt   <= '0;
                     o_job_done <= 1'b1;
                     state      <= DONE;
                  end else if (tile_cnt == TILE_LAST) begin
                     tile_cnt <= '0;
                     qto_cnt  <= '0;
                     state    <= WAIT_QUANT;
                  end else begin
                     tile_cnt <= tile_cnt + 1'b1;
                     state    <= WAIT_TILE;
                  end
               end else begin
                  acc_cnt <= acc_cnt + 1'b1;
               end
            end
            WAIT_QUANT: begin
               if (i_abort) begin
                  o_job_done <= 1'b1;
                  state      <= DONE;
               end else if (i_sf_valid || qto_exp) begin
                  // a timeout counts as a finished vector so the job can drain
                  if (!i_sf_valid) o_err_timeout <= 1'b1;
                  o_vec_cnt <= o_vec_cnt + VEC_ONE;
                  if (last_vec) begin
                     o_job_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     state <= WAIT_TILE;
                  end
               end else begin
                  qto_cnt <= qto_cnt + 1'b1;
               end
            end
            DONE: begin
               // queued job: go straight to LOAD so relu_en switches without a gap
               if (pop) begin
                  nvec_q    <= head.nvec;
                  o_relu_en <= head.relu;
                  o_vec_cnt <= '0;
                  tile_cnt  <= '0;
                  state     <= LOAD;
               end else begin
                  o_relu_en <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ppu_sched.sv
// tb_ppu_sched: directed scenarios for ppu_sched, one task per feature.
module tb_ppu_sched;
   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_job_valid = 1'b0;
   logic       o_job_ready;
   logic [7:0] i_job_nvec = '0;
   logic       i_job_relu = 1'b0;
   logic       i_tile_valid = 1'b0;
   logic       o_tile_ack;
   logic       o_ppu_start;
   logic       o_relu_en;
   logic       i_sf_valid = 1'b0;
   logic       i_abort = 1'b0;
   logic       i_err_clr = 1'b0;
   logic       o_busy;
   logic       o_job_done;
   logic [7:0] o_vec_cnt;
   logic       o_err_timeout;

   int n_chk = 0;
   int n_pass = 0;

   ppu_sched #(.NVEC_W(8), .TILE_CYC(16), .TILES_PER_VEC(4), .QTO_W(8)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
      .i_job_nvec(i_job_nvec), .i_job_relu(i_job_relu),
      .i_tile_valid(i_tile_valid), .o_tile_ack(o_tile_ack),
      .o_ppu_start(o_ppu_start), .o_relu_en(o_relu_en),
      .i_sf_valid(i_sf_valid), .i_abort(i_abort), .i_err_clr(i_err_clr),
      .o_busy(o_busy), .o_job_done(o_job_done), .o_vec_cnt(o_vec_cnt),
      .o_err_timeout(o_err_timeout)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // pulse recorder, sampled on the falling edge
   int   n_start = 0;
   int   n_done = 0;
   int   ack_bad = 0;
   int   start_t [64];
   int   done_t [64];
   logic done_relu [64];
   always @(negedge i_clk) begin
      if (o_ppu_start !== o_tile_ack) ack_bad = ack_bad + 1;
      if (o_ppu_start === 1'b1) begin
         if (n_start < 64) start_t[n_start] = cyc;
         n_start = n_start + 1;
      end
      if (o_job_done === 1'b1) begin
         if (n_done < 64) begin
            done_t[n_done]    = cyc;
            done_relu[n_done] = o_relu_en;
         end
         n_done = n_done + 1;
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] nv, input logic r);
      i_job_valid = 1'b1;
      i_job_nvec  = nv;
      i_job_relu  = r;
      step();
      i_job_valid = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      step(); step();
      n_chk++;
      if ({o_job_ready, o_tile_ack, o_ppu_start, o_relu_en, o_busy, o_job_done, o_err_timeout} !== 7'b0)
         $display("FAIL reset_flags: got %b want 0000000",
                  {o_job_ready, o_tile_ack, o_ppu_start, o_relu_en, o_busy, o_job_done, o_err_timeout});
      else n_pass++;
      n_chk++;
      if (o_vec_cnt !== 8'd0) $display("FAIL reset_vec_cnt: got %0d want 0", o_vec_cnt);
      else n_pass++;
      i_rst_n = 1'b1;
      #1;
      n_chk++;
      if (o_job_ready !== 1'b0) $display("FAIL reset_ready_at_release: got %b want 0", o_job_ready);
      else n_pass++;
      step();
      n_chk++;
      if (o_job_ready !== 1'b1) $display("FAIL reset_ready_first_cycle: got %b want 1", o_job_ready);
      else n_pass++;
   endtask

   task automatic test_single();
      int p, bs, bd, bad;
      bs = n_start; bd = n_done; bad = 0;
      i_tile_valid = 1'b1; i_sf_valid = 1'b0;
      push(8'd1, 1'b1); p = cyc;
      step();
      if (o_relu_en !== 1'b1) bad++;
      while (cyc < p + 80) begin
         step();
         if (o_relu_en !== 1'b1) bad++;
      end
      n_chk++;
      if (bad !== 0) $display("FAIL single_relu_held: %0d cycles low, want 0", bad);
      else n_pass++;
      n_chk++;
      if (n_start - bs !== 4) $display("FAIL single_start_count: got %0d want 4", n_start - bs);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_chk++;
         if (start_t[bs+k] !== p + 3 + 17*k)
            $display("FAIL single_start_time[%0d]: got %0d want %0d", k, start_t[bs+k] - p, 3 + 17*k);
         else n_pass++;
      end
      n_chk++;
      if ({o_busy, 1'(n_done != bd)} !== 2'b10)
         $display("FAIL single_wait_quant: busy=%b done_seen=%b want busy=1 done_seen=0", o_busy, n_done != bd);
      else n_pass++;
      i_sf_valid = 1'b1;
      step();
      i_sf_valid = 1'b0;
      n_chk++;
      if ({o_job_done, o_vec_cnt} !== {1'b1, 8'd1})
         $display("FAIL single_done: got done=%b vec=%0d want done=1 vec=1", o_job_done, o_vec_cnt);
      else n_pass++;
      step();
      n_chk++;
      if ({o_job_done, o_relu_en, o_busy} !== 3'b000)
         $display("FAIL single_idle: got done/relu/busy=%b want 000", {o_job_done, o_relu_en, o_busy});
      else n_pass++;
   endtask

   task automatic test_zero();
      int p, bs, bd;
      bs = n_start; bd = n_done;
      i_tile_valid = 1'b0;
      push(8'd0, 1'b1); p = cyc;
      while (cyc < p + 6) step();
      n_chk++;
      if (n_done - bd !== 1) $display("FAIL zero_done_count: got %0d want 1", n_done - bd);
      else n_pass++;
      n_chk++;
      if (done_t[bd] !== p + 2) $display("FAIL zero_done_time: got %0d want 2", done_t[bd] - p);
      else n_pass++;
      n_chk++;
      if (n_start - bs !== 0) $display("FAIL zero_starts: got %0d want 0", n_start - bs);
      else n_pass++;
      n_chk++;
      if ({o_busy, o_vec_cnt} !== 9'd0) $display("FAIL zero_idle: got busy=%b vec=%0d want 0 0", o_busy, o_vec_cnt);
      else n_pass++;
   endtask

   task automatic test_tile_gaps();
      int p, bs, bd, ba;
      int exp_s [8];
      logic hit;
      bs = n_start; bd = n_done; ba = ack_bad;
      i_tile_valid = 1'b0; i_sf_valid = 1'b1;
      push(8'd2, 1'b0); p = cyc;
      // each tile waits 5 cycles in WAIT_TILE; vector boundary adds one WAIT_QUANT cycle
      exp_s[0] = p + 8;
      for (int k = 1; k < 8; k++) exp_s[k] = exp_s[k-1] + 22 + ((k == 4) ? 1 : 0);
      while (cyc < p + 186) begin
         hit = 1'b0;
         for (int k = 0; k < 8; k++) if (exp_s[k] == cyc + 1) hit = 1'b1;
         i_tile_valid = hit;
         step();
      end
      i_tile_valid = 1'b0; i_sf_valid = 1'b0;
      n_chk++;
      if (n_start - bs !== 8) $display("FAIL gaps_start_count: got %0d want 8", n_start - bs);
      else n_pass++;
      for (int k = 0; k < 8; k++) begin
         n_chk++;
         if (start_t[bs+k] !== exp_s[k])
            $display("FAIL gaps_start_time[%0d]: got %0d want %0d", k, start_t[bs+k] - p, exp_s[k] - p);
         else n_pass++;
      end
      n_chk++;
      if (ack_bad - ba !== 0) $display("FAIL gaps_ack_coincident: %0d mismatched cycles want 0", ack_bad - ba);
      else n_pass++;
      n_chk++;
      if ({1'(n_done - bd == 1), o_vec_cnt} !== {1'b1, 8'd2})
         $display("FAIL gaps_done: got dones=%0d vec=%0d want 1 2", n_done - bd, o_vec_cnt);
      else n_pass++;
      n_chk++;
      if (done_t[bd] !== exp_s[7] + 17) $display("FAIL gaps_done_time: got %0d want %0d", done_t[bd] - p, exp_s[7] + 17 - p);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int bd;
      logic d_pushed;
      bd = n_done; d_pushed = 1'b0;
      i_tile_valid = 1'b0; i_sf_valid = 1'b0;
      push(8'd1, 1'b1);
      step(); step();
      n_chk++;
      if ({o_busy, o_relu_en} !== 2'b11) $display("FAIL b2b_job_a_active: got busy/relu=%b want 11", {o_busy, o_relu_en});
      else n_pass++;
      push(8'd0, 1'b0);
      push(8'd0, 1'b1);
      n_chk++;
      if (o_job_ready !== 1'b0) $display("FAIL b2b_ready_full: got %b want 0", o_job_ready);
      else n_pass++;
      i_job_valid = 1'b1; i_job_nvec = 8'd0; i_job_relu = 1'b0;
      i_tile_valid = 1'b1; i_sf_valid = 1'b1;
      for (int k = 0; k < 400 && (n_done - bd) < 4; k++) begin
         if (i_job_valid && o_job_ready) begin
            step();
            i_job_valid = 1'b0;
            d_pushed = 1'b1;
         end else begin
            step();
         end
      end
      i_job_valid = 1'b0; i_tile_valid = 1'b0; i_sf_valid = 1'b0;
      step(); step();
      n_chk++;
      if ({d_pushed, 1'(n_done - bd == 4)} !== 2'b11)
         $display("FAIL b2b_all_done: got pushed=%b dones=%0d want 1 4", d_pushed, n_done - bd);
      else n_pass++;
      n_chk++;
      if ({done_relu[bd], done_relu[bd+1], done_relu[bd+2], done_relu[bd+3]} !== 4'b1010)
         $display("FAIL b2b_relu_order: got %b want 1010",
                  {done_relu[bd], done_relu[bd+1], done_relu[bd+2], done_relu[bd+3]});
      else n_pass++;
      n_chk++;
      if ({o_busy, o_job_ready, o_relu_en} !== 3'b010)
         $display("FAIL b2b_idle: got busy/ready/relu=%b want 010", {o_busy, o_job_ready, o_relu_en});
      else n_pass++;
   endtask

   task automatic test_timeout(input logic hold_clr);
      int p, bd;
      bd = n_done;
      i_tile_valid = 1'b1; i_sf_valid = 1'b0; i_err_clr = hold_clr;
      push(8'd1, 1'b0); p = cyc;
      while (cyc < p + 324) step();
      n_chk++;
      if (o_err_timeout !== 1'b0) $display("FAIL timeout_early[clr=%b]: got %b want 0", hold_clr, o_err_timeout);
      else n_pass++;
      step();
      n_chk++;
      if ({o_err_timeout, o_job_done} !== 2'b11)
         $display("FAIL timeout_expire[clr=%b]: got err/done=%b want 11", hold_clr, {o_err_timeout, o_job_done});
      else n_pass++;
      step(); step();
      n_chk++;
      if ({o_err_timeout, o_busy, 1'(n_done - bd == 1)} !== {~hold_clr, 2'b01})
         $display("FAIL timeout_after[clr=%b]: got err/busy/one_done=%b want %b",
                  hold_clr, {o_err_timeout, o_busy, 1'(n_done - bd == 1)}, {~hold_clr, 2'b01});
      else n_pass++;
      i_err_clr = 1'b1;
      step();
      i_err_clr = 1'b0;
      n_chk++;
      if (o_err_timeout !== 1'b0) $display("FAIL timeout_clear[clr=%b]: got %b want 0", hold_clr, o_err_timeout);
      else n_pass++;
      i_tile_valid = 1'b0;
   endtask

   task automatic test_abort();
      int p, bs, bd;
      bs = n_start; bd = n_done;
      i_tile_valid = 1'b1; i_sf_valid = 1'b0;
      push(8'd1, 1'b1); p = cyc;
      while (cyc < p + 21) step();
      push(8'd0, 1'b0);
      while (cyc < p + 25) step();
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      while (cyc < p + 60) step();
      i_tile_valid = 1'b0;
      n_chk++;
      if ({1'(n_start - bs == 2), 1'(start_t[bs+1] == p + 20)} !== 2'b11)
         $display("FAIL abort_starts: got count=%0d t1=%0d want 2 20", n_start - bs, start_t[bs+1] - p);
      else n_pass++;
      n_chk++;
      if (n_done - bd !== 1) $display("FAIL abort_done_count: got %0d want 1", n_done - bd);
      else n_pass++;
      n_chk++;
      if (done_t[bd] !== p + 36) $display("FAIL abort_done_time: got %0d want 36", done_t[bd] - p);
      else n_pass++;
      n_chk++;
      if ({o_busy, o_relu_en, o_job_ready} !== 3'b001)
         $display("FAIL abort_idle: got busy/relu/ready=%b want 001", {o_busy, o_relu_en, o_job_ready});
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      int p, bs, bd;
      bs = n_start; bd = n_done;
      i_tile_valid = 1'b1;
      push(8'd1, 1'b1); p = cyc;
      while (cyc < p + 10) step();
      i_rst_n = 1'b0;
      #1;
      n_chk++;
      if ({o_busy, o_relu_en, o_ppu_start, o_job_ready} !== 4'b0000)
         $display("FAIL rst_mid_outputs: got busy/relu/start/ready=%b want 0000",
                  {o_busy, o_relu_en, o_ppu_start, o_job_ready});
      else n_pass++;
      step(); step(); step();
      i_rst_n = 1'b1;
      for (int k = 0; k < 40; k++) step();
      i_tile_valid = 1'b0;
      n_chk++;
      if ({1'(n_start - bs == 1), 1'(n_done - bd == 0), o_busy, o_job_ready} !== 4'b1101)
         $display("FAIL rst_mid_after: got starts=%0d dones=%0d busy=%b ready=%b want 1 0 0 1",
                  n_start - bs, n_done - bd, o_busy, o_job_ready);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero();
      test_tile_gaps();
      test_back_to_back();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_abort();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
